// File: rtl/machine_timer.sv
// Machine timer / software-interrupt unit (CLINT-style).
// Provides 64-bit mtime/mtimecmp and msip behind a single-cycle bus.
// Also drives the level-sensitive pending lines that feed mip.MTIP and mip.MSIP.
module machine_timer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [7:0]  PRESCALE_RST = 8'd0,
  parameter logic        EN_RST       = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [7:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  timer_irq_o,
  output logic                  sw_irq_o
);

  typedef enum logic [5:0] {
    REG_MTIME_LO = 6'h00,
    REG_MTIME_HI = 6'h01,
    REG_CMP_LO   = 6'h02,
    REG_CMP_HI   = 6'h03,
    REG_MSIP     = 6'h04,
    REG_CTRL     = 6'h05
  } reg_e;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        en;
  logic [7:0]  prescale;
  logic [7:0]  pcnt;
  logic [31:0] hi_snap;

  reg_e        sel;
  logic        hit;
  logic [31:0] rd_val;
  logic        tick;
  logic        wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_msip, wr_ctrl, rd_lo;
  logic        unused_addr_lsb;

  // The two byte-offset bits never participate in decode.
  assign unused_addr_lsb = ^addr_i[1:0];
  assign sel  = reg_e'(addr_i[7:2]);
  assign tick = en && (pcnt == prescale);

  // Register decode and read-data mux.
  always_comb begin
    hit    = 1'b1;
    rd_val = '0;
    case (sel)
      REG_MTIME_LO: rd_val = mtime[31:0];
      REG_MTIME_HI: rd_val = hi_snap;
      REG_CMP_LO:   rd_val = mtimecmp[31:0];
      REG_CMP_HI:   rd_val = mtimecmp[63:32];
      REG_MSIP:     rd_val = {31'd0, msip};
      REG_CTRL:     rd_val = {16'd0, prescale, 7'd0, en};
      default:      hit    = 1'b0;
    endcase
  end

  // Per-register access strobes for the current bus cycle.
  always_comb begin
    wr_lo     = req_i && we_i && (sel == REG_MTIME_LO);
    wr_hi     = req_i && we_i && (sel == REG_MTIME_HI);
    wr_cmp_lo = req_i && we_i && (sel == REG_CMP_LO);
    wr_cmp_hi = req_i && we_i && (sel == REG_CMP_HI);
    wr_msip   = req_i && we_i && (sel == REG_MSIP);
    wr_ctrl   = req_i && we_i && (sel == REG_CTRL);
    rd_lo     = req_i && !we_i && (sel == REG_MTIME_LO);
  end

  // Prescaler and mtime; a write to either half suppresses that cycle's increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mtime <= '0;
      pcnt  <= '0;
    end else begin
      if (wr_lo)      mtime[31:0]  <= wdata_i;
      else if (wr_hi) mtime[63:32] <= wdata_i;
      else if (tick)  mtime        <= mtime + 64'd1;

      if (wr_ctrl)    pcnt <= '0;
      else if (en)    pcnt <= tick ? 8'd0 : pcnt + 8'd1;
    end
  end

  // Software-visible control registers and the mtime high-half snapshot.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
      en       <= EN_RST;
      prescale <= PRESCALE_RST;
      hi_snap  <= '0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= wdata_i;
      if (wr_cmp_hi) mtimecmp[63:32] <= wdata_i;
      if (wr_msip)   msip            <= wdata_i[0];
      if (wr_ctrl) begin
        en       <= wdata_i[0];
        prescale <= wdata_i[15:8];
      end
      if (rd_lo)     hi_snap <= mtime[63:32];
    end
  end

  // Registered bus response, one cycle after each request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o   <= req_i;
      err_o   <= req_i && !hit;
      rdata_o <= (req_i && !we_i && hit) ? rd_val : '0;
    end
  end

  // Registered interrupt pending levels.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_irq_o <= 1'b0;
      sw_irq_o    <= 1'b0;
    end else begin
      timer_irq_o <= (mtime >= mtimecmp);
      sw_irq_o    <= msip;
    end
  end

endmodule
